vga_tile_arbiter: RTL
=====================

# vga_tile_arbiter

Shares the single-port tile memory between the VGA display fetch path and the draw/game-logic writer. It sits between the sync generator (display_en, x_pos, y_pos) and a synchronous 8-bit-wide RAM of 100×75 tiles, where each tile is 8×8 pixels at 800×600. Display fetches always win. Writer requests and a hardware clear sequencer use every remaining cycle.

## Interface
- TILES_X, 100, tiles per row (800/8)
- TILES_Y, 75, tile rows (600/8)
- DEPTH, 7500, memory words (TILES_X*TILES_Y)
- AW, 13, address width
- DW, 8, data width

- clk  in  1  pixel clock
- rst  in  1  reset, asynchronous, active-high
- display_en  in  1  visible-area flag from sync generator
- x_pos  in  11  pixel column; valid only while display_en=1
- y_pos  in  11  pixel row; valid only while display_en=1
- wr_req  in  1  writer request; held with wr_addr/wr_data stable until wr_ack
- wr_addr  in  AW  writer tile address
- wr_data  in  DW  writer tile data
- wr_ack  out  1  write performed this cycle (combinational, coincident with mem_we)
- clear_start  in  1  one-cycle pulse: fill whole memory with clear_data
- clear_data  in  DW  fill value, sampled on accepted clear_start
- clear_busy  out  1  clear in progress
- clear_done  out  1  one-cycle pulse after last clear write
- mem_addr  out  AW  RAM address (combinational)
- mem_we  out  1  RAM write enable (combinational)
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, valid one cycle after address
- tile_data  out  DW  fetched tile for display pipeline
- tile_valid  out  1  one-cycle pulse, tile_data updated

## Operation
- Fetch slot: fetch = display_en && x_pos[2:0]==0.
  - mem_addr = y_pos[10:3]*TILES_X + x_pos[10:3], truncated to AW.
  - mem_we=0.
  - Fetch preempts every other use.
- Free cycle: any cycle that is not a fetch slot.
- FSM states IDLE and CLEAR. The reset state is IDLE.
- IDLE:
  - Free cycle with clear_start=1: latch clear_data, set counter=0, go to CLEAR. No write that cycle; wr_ack=0. clear_start has priority over wr_req.
  - Free cycle with wr_req=1 and clear_start=0: mem_addr=wr_addr, mem_wdata=wr_data, mem_we=1, wr_ack=1.
  - Fetch slot with clear_start=1: clear request held pending internally, accepted on the next free cycle.
  - Fetch slot with wr_req=1: wr_ack=0, and the requester keeps holding.
- CLEAR:
  - Each free cycle: write latched value to address counter, then counter+1.
  - Writing at counter=DEPTH-1 returns to IDLE.
  - clear_done=1 on the following cycle.
  - clear_busy is registered: high from the cycle after acceptance through the last write cycle.
  - wr_req stalls (wr_ack=0) for the whole clear.
  - clear_start is ignored while in CLEAR or while a clear is pending.
- Idle behaviour: when there is no fetch and no write, mem_addr holds its last value and mem_we=0.

## Timing
- Reset (async, immediate) sets state=IDLE, counter=0, pending=0, tile_data=0, tile_valid=0, clear_busy=0, clear_done=0. While rst=1, mem_we=0 and wr_ack=0.
- Fetch latency:
  - Address at cycle N.
  - mem_rdata at N+1.
  - tile_data/tile_valid registered, visible at N+2.
  - The downstream pixel path delays x/y by 2 to match.
- Write latency:
  - Ack in the same cycle as the request when the cycle is free.
  - Worst case 2 cycles, because fetch slots are never adjacent.
- Clear duration: DEPTH free cycles.
  - 7500 cycles if started in blanking with no intervening visible area.
  - In visible area, 7 of every 8 cycles progress.
- Reset mid-clear aborts immediately. The memory is partially cleared and no clear_done is issued.
- Address arithmetic is unsigned, computed at full width and then truncated to AW. Inputs outside 800×600 are never presented, because display_en gates them.

## Test plan
- Reset: rst pulse mid-frame → all outputs 0 asynchronously; first free cycle after release with wr_req=1 gives wr_ack=1.
- Fetch: display_en=1, x_pos=16, y_pos=8, mem_rdata=0x5A one cycle later → mem_addr=102, mem_we=0, tile_data=0x5A with tile_valid at N+2.
- Collision: wr_req (addr 37, data 0xC3) raised at x_pos=8, display_en=1 → no ack at x=8; ack with mem_we=1, mem_addr=37 at x=9.
- Blanking write burst: display_en=0, wr_req held for 4 addresses → 4 consecutive acks, one per cycle.
- Clear in blanking, clear_data=0x00:
  - 7500 writes to addresses 0..7499.
  - clear_busy high throughout.
  - Single clear_done pulse on the following cycle.
  - Concurrent wr_req gets no ack until after clear_done.
- Simultaneous clear_start and wr_req in IDLE on a free cycle → clear accepted, wr_ack=0. A second clear_start during CLEAR → ignored, exactly one clear_done.

Source files
------------

// File: rtl/vga_tile_arbiter.sv
// vga_tile_arbiter: shares the single-port tile RAM between the VGA tile
// fetch path (absolute priority), a handshaked tile writer and a hardware
// clear sequencer that fills the whole memory with one value.
module vga_tile_arbiter #(
   parameter int unsigned TILES_X = 100,
   parameter int unsigned TILES_Y = 75,
   parameter int unsigned DEPTH   = TILES_X * TILES_Y,
   parameter int unsigned AW      = 13,
   parameter int unsigned DW      = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          display_en,
   input  logic [10:0]   x_pos,
   input  logic [10:0]   y_pos,
   input  logic          wr_req,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   output logic          wr_ack,
   input  logic          clear_start,
   input  logic [DW-1:0] clear_data,
   output logic          clear_busy,
   output logic          clear_done,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic [DW-1:0] tile_data,
   output logic          tile_valid
);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t        state, state_n;
   logic [AW-1:0] counter;
   logic [AW-1:0] addr_q;
   logic [AW-1:0] fetch_addr;
   logic [DW-1:0] clear_val;
   logic          pending;
   logic          fetch;
   logic          fetch_d1;
   logic          accept;
   logic          clear_wr;
   logic          last_wr;
   logic          unused_ypos_lsbs;

   // Pixel row within a tile does not affect the tile address.
   assign unused_ypos_lsbs = ^y_pos[2:0];

   // Fetch slot detection and tile address from the pixel position
   always_comb begin
      fetch      = display_en && (x_pos[2:0] == 3'd0);
      fetch_addr = AW'(32'(y_pos[10:3]) * TILES_X + 32'(x_pos[10:3]));
   end

   // Next state and RAM port mux: fetch first, then clear or writer
   always_comb begin
      state_n   = state;
      accept    = 1'b0;
      clear_wr  = 1'b0;
      last_wr   = 1'b0;
      mem_addr  = addr_q;
      mem_we    = 1'b0;
      mem_wdata = wr_data;
      wr_ack    = 1'b0;
      if (fetch) begin
         mem_addr = fetch_addr;
      end else begin
         case (state)
            IDLE: begin
               if (clear_start || pending) begin
                  accept  = 1'b1;
                  state_n = CLEAR;
               end else if (wr_req) begin
                  mem_addr = wr_addr;
                  mem_we   = 1'b1;
                  wr_ack   = 1'b1;
               end
            end
            CLEAR: begin
               clear_wr  = 1'b1;
               mem_addr  = counter;
               mem_we    = 1'b1;
               mem_wdata = clear_val;
               if (counter == AW'(DEPTH - 1)) begin
                  last_wr = 1'b1;
                  state_n = IDLE;
               end
            end
            default: state_n = IDLE;
         endcase
      end
      if (rst) begin
         mem_addr  = '0;
         mem_we    = 1'b0;
         mem_wdata = '0;
         wr_ack    = 1'b0;
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Clear bookkeeping, pending request and held RAM address
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         counter    <= '0;
         pending    <= 1'b0;
         clear_val  <= '0;
         clear_busy <= 1'b0;
         clear_done <= 1'b0;
         addr_q     <= '0;
      end else begin
         addr_q     <= mem_addr;
         clear_done <= last_wr;
         // Fill value is taken from the pulse itself, even if acceptance
         // is deferred past a fetch slot.
         if (state == IDLE && clear_start && !pending) clear_val <= clear_data;
         if (accept) begin
            pending    <= 1'b0;
            counter    <= '0;
            clear_busy <= 1'b1;
         end else if (state == IDLE && clear_start && fetch) begin
            pending <= 1'b1;
         end
         if (clear_wr) begin
            counter <= counter + 1'b1;
            if (last_wr) clear_busy <= 1'b0;
         end
      end
   end

   // Display return path: RAM data arrives one cycle after the fetch slot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_d1   <= 1'b0;
         tile_valid <= 1'b0;
         tile_data  <= '0;
      end else begin
         fetch_d1   <= fetch;
         tile_valid <= fetch_d1;
         if (fetch_d1) tile_data <= mem_rdata;
      end
   end

endmodule
